mio_bus_resp: RTL and testbench

//   Memory/IO bus responder on the slave end of the single-cycle CPU's MIO interface.

---
 rtl/mio_bus_resp_if.sv | 28 ++
 rtl/mio_bus_resp.sv | 160 ++++++++++++++++
 tb/tb_mio_bus_resp.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mio_bus_resp_if.sv
// MIO request/response bundle between the CPU (master) and responder (slave).
// Carries mem_req/mem_w/addr/data_in down and data_out/MIO_ready back up.
interface mio_bus_resp_if;
  logic        mem_req;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        MIO_ready;

  modport master (
    output mem_req,
    output mem_w,
    output addr,
    output data_in,
    input  data_out,
    input  MIO_ready
  );

  modport slave (
    input  mem_req,
    input  mem_w,
    input  addr,
    input  data_in,
    output data_out,
    output MIO_ready
  );
endinterface

// File: rtl/mio_bus_resp.sv
// MIO bus responder: decodes CPU loads/stores to word RAM, GPIO, countdown timer.
// Ports: clk, reset (async low), bus (slave: req/w/addr/data_in -> data_out/
// MIO_ready), ram_addr/ram_din/ram_we/ram_dout, led_out, sw_in, cnt_done.
// Define MIO_BUS_ERR_EN to add a bus_err output flagging unmapped accesses.
module mio_bus_resp #(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 2,
  parameter int LED_W    = 16,
  parameter int SW_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  mio_bus_resp_if.slave     bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  output logic [LED_W-1:0]  led_out,
  input  logic [SW_W-1:0]   sw_in,
  output logic              cnt_done
`ifdef MIO_BUS_ERR_EN
  ,
  output logic              bus_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    R_RAM,
    R_GPIO,
    R_TMR,
    R_NONE
  } rgn_t;

  localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT - 1);

  state_t      state;
  rgn_t        rgn;
  rgn_t        cur_rgn;
  logic        cur_w;
  logic [3:0]  wcnt;
  logic        ready_q;
  logic        we_q;
  logic [31:0] dout_q;
  logic [31:0] rd_mux;
  logic [31:0] sw_ext;
  logic [31:0] tmr;
  logic        commit;
  logic        unused_ok;

  assign ram_addr      = bus.addr[RAM_AW+1:2];
  assign ram_din       = bus.data_in;
  assign ram_we        = we_q;
  assign bus.data_out  = dout_q;
  assign bus.MIO_ready = ready_q;
  assign cnt_done      = (tmr == '0);

  assign unused_ok = ^{bus.addr[27:RAM_AW+2], bus.addr[1:0]};

`ifdef MIO_BUS_ERR_EN
  // cur_rgn is stable through RESP, so this pulses exactly with MIO_ready.
  assign bus_err = ready_q & (cur_rgn == R_NONE);
`endif

  always_comb begin
    rgn = R_NONE;
    unique case (1'b1)
      (bus.addr[31:28] == 4'h0): rgn = R_RAM;
      (bus.addr[31:28] == 4'hE): rgn = R_GPIO;
      (bus.addr[31:28] == 4'hF): rgn = R_TMR;
      default:                   rgn = R_NONE;
    endcase
  end

  always_comb begin
    sw_ext = '0;
    sw_ext[SW_W-1:0] = sw_in;
  end

  always_comb begin
    rd_mux = '0;
    unique case (rgn)
      R_RAM:   rd_mux = ram_dout;
      R_GPIO:  rd_mux = sw_ext;
      R_TMR:   rd_mux = tmr;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      cur_rgn <= R_NONE;
      cur_w   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.mem_req) begin
            cur_rgn <= rgn;
            cur_w   <= bus.mem_w;
            if (rgn == R_RAM) begin
              state <= S_WAIT;
              wcnt  <= WAIT_INIT;
            end else begin
              state   <= S_RESP;
              ready_q <= 1'b1;
              dout_q  <= rd_mux;
            end
          end
        end
        S_WAIT: begin
          if (wcnt == '0) begin
            state   <= S_RESP;
            ready_q <= 1'b1;
            we_q    <= cur_w;
            dout_q  <= ram_dout;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // IO stores take effect on the edge that ends the response cycle.
  assign commit = (state == S_RESP) & cur_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_out <= '0;
    end else if (commit && cur_rgn == R_GPIO) begin
      led_out <= bus.data_in[LED_W-1:0];
    end
  end

  // A load wins over the decrement on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr <= '0;
    end else if (commit && cur_rgn == R_TMR) begin
      tmr <= bus.data_in;
    end else if (tmr != '0) begin
      tmr <= tmr - 32'd1;
    end
  end

endmodule

// File: tb/tb_mio_bus_resp.sv
// Directed bench for mio_bus_resp with a scoreboard of expected responses.
// Covers RAM, GPIO, timer, unmapped, mid-access reset and back-to-back loads.
module tb_mio_bus_resp;
  localparam int RAM_AW   = 10;
  localparam int RAM_WAIT = 2;
  localparam int LED_W    = 16;
  localparam int SW_W     = 16;

  typedef struct {
    logic        chk;
    logic [31:0] data;
    int          lat;
    logic        we;
    logic        err;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_we;
  logic [31:0]       ram_dout;
  logic [LED_W-1:0]  led_out;
  logic [SW_W-1:0]   sw_in;
  logic              cnt_done;
`ifdef MIO_BUS_ERR_EN
  logic              bus_err;
`endif

  logic [31:0] mem [0:(1<<RAM_AW)-1] = '{default: 32'h0};
  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  mio_bus_resp_if bus();

  mio_bus_resp #(
    .RAM_AW  (RAM_AW),
    .RAM_WAIT(RAM_WAIT),
    .LED_W   (LED_W),
    .SW_W    (SW_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .ram_addr(ram_addr),
    .ram_din (ram_din),
    .ram_we  (ram_we),
    .ram_dout(ram_dout),
    .led_out (led_out),
    .sw_in   (sw_in),
    .cnt_done(cnt_done)
`ifdef MIO_BUS_ERR_EN
    ,
    .bus_err (bus_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      if (e.chk) check({tag, "_data"}, bus.data_out, e.data);
      check({tag, "_we"}, ram_we, e.we);
`ifdef MIO_BUS_ERR_EN
      check({tag, "_err"}, bus_err, e.err);
`endif
    end
  endtask

  // Called #1 after a posedge; returns #1 after the edge that ends RESP.
  task automatic access(input string tag, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic chk, input logic [31:0] exp_d);
    exp_t e;
    int   n;
    bit   ram;
    ram    = (a[31:28] == 4'h0);
    e.chk  = chk;
    e.data = exp_d;
    e.lat  = ram ? 1 + RAM_WAIT : 1;
    e.we   = ram & w;
    e.err  = (a[31:28] != 4'h0) && (a[31:28] != 4'hE) && (a[31:28] != 4'hF);
    sb.push_back(e);
    bus.mem_req = 1'b1;
    bus.mem_w   = w;
    bus.addr    = a;
    bus.data_in = d;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1 && ram)
        check({tag, "_raddr"}, 32'(ram_addr), 32'(a[RAM_AW+1:2]));
      if (bus.MIO_ready === 1'b1) break;
      if (ram_we !== 1'b0) check({tag, "_early_we"}, ram_we, 32'd0);
      if (n > 40) break;
    end
    check({tag, "_lat"}, n, e.lat + 1);
    if (bus.MIO_ready === 1'b1) pop_check(tag);
    else void'(sb.pop_front());
    @(posedge clk);
    #1;
    bus.mem_req = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_w   = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    sw_in       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.MIO_ready, 32'd0);
    check("rst_dout", bus.data_out, 32'd0);
    check("rst_we", ram_we, 32'd0);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_done", cnt_done, 32'd1);
`ifdef MIO_BUS_ERR_EN
    check("rst_err", bus_err, 32'd0);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;

    access("ram_st", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
    access("ram_ld", 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF);
    access("ram_st_top", 1'b1, 32'h0000_0FFF, 32'h0BAD_F00D, 1'b0, 32'h0);
    access("ram_ld_top", 1'b0, 32'h0000_0FFC, 32'h0, 1'b1, 32'h0BAD_F00D);
    access("ram_ld_nil", 1'b0, 32'h0000_0014, 32'h0, 1'b1, 32'h0);

    access("gpio_st", 1'b1, 32'hE000_0000, 32'h0000_A5A5, 1'b0, 32'h0);
    check("gpio_led", 32'(led_out), 32'h0000_A5A5);
    sw_in = 16'h1234;
    access("gpio_ld", 1'b0, 32'hE000_0004, 32'h0, 1'b1, 32'h0000_1234);

    access("unm_ld", 1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0);
    access("unm_st", 1'b1, 32'h8000_0000, 32'h0000_FFFF, 1'b0, 32'h0);
    check("unm_led", 32'(led_out), 32'h0000_A5A5);

    access("tmr_st5", 1'b1, 32'hF000_0000, 32'd5, 1'b0, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("tmr_done_k%0d", k), cnt_done, 32'(k >= 6));
    end
    @(posedge clk);
    #1;
    access("tmr_st5b", 1'b1, 32'hF000_0000, 32'd5, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    access("tmr_st7", 1'b1, 32'hF000_0000, 32'd7, 1'b0, 32'h0);
    access("tmr_rd7", 1'b0, 32'hF000_0000, 32'h0, 1'b1, 32'd7);
    access("tmr_rd5", 1'b0, 32'hF000_0000, 32'h0, 1'b1, 32'd5);
    check("tmr_busy", cnt_done, 32'd0);

    access("tmr_big", 1'b1, 32'hF000_0000, 32'd1000, 1'b0, 32'h0);
    check("pre_rst_done", cnt_done, 32'd0);
    bus.mem_req = 1'b1;
    bus.mem_w   = 1'b1;
    bus.addr    = 32'h0000_0020;
    bus.data_in = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_led", 32'(led_out), 32'd0);
    check("mid_rst_done", cnt_done, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_rst_ready", bus.MIO_ready, 32'd0);
      check("mid_rst_we", ram_we, 32'd0);
    end
    bus.mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    access("post_rst_gpio", 1'b0, 32'hE000_0000, 32'h0, 1'b1, 32'h0000_1234);
    access("post_rst_ram", 1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'h0);

    begin
      exp_t e;
      e.chk  = 1'b1;
      e.lat  = 1;
      e.we   = 1'b0;
      e.err  = 1'b0;
      e.data = 32'h0000_1234;
      sb.push_back(e);
      e.data = 32'h0000_5678;
      sb.push_back(e);
    end
    bus.mem_req = 1'b1;
    bus.mem_w   = 1'b0;
    bus.addr    = 32'hE000_0000;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      check($sformatf("b2b_rdy_n%0d", n), bus.MIO_ready,
            32'((n == 2) || (n == 4)));
      if (bus.MIO_ready === 1'b1) pop_check("b2b");
      if (n == 2) sw_in = 16'h5678;
    end
    @(posedge clk);
    #1;
    bus.mem_req = 1'b0;
    @(negedge clk);
    check("b2b_idle", bus.MIO_ready, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
